// File: rtl/sa_sched.sv
// sa_sched: sequencing controller for an N x N weight-stationary systolic array.
// Walks a job through weight load, activation streaming and result drain, and
// derives the per-row activation and per-column output-valid strobes from a
// single shift register fed by the activation read enable.
module sa_sched #(
    parameter int N     = 8,
    parameter int LEN_W = 8,
    parameter int AW    = $clog2(N)
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic             reuse_w,
    input  logic [LEN_W-1:0] num_vec,
    output logic             busy,
    output logic             done,
    output logic             w_rd_en,
    output logic [AW-1:0]    w_rd_addr,
    output logic             w_shift_en,
    output logic             a_rd_en,
    output logic [LEN_W-1:0] a_rd_addr,
    output logic [N-1:0]     row_valid,
    output logic [N-1:0]     col_out_valid
);

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        LOAD_W  = 3'd1,
        COMPUTE = 3'd2,
        DRAIN   = 3'd3,
        FIN     = 3'd4
    } state_t;

    state_t             state_r, state_s;
    logic [AW-1:0]      w_cnt_r, w_cnt_s;
    logic [LEN_W-1:0]   v_cnt_r, v_cnt_s;
    logic [LEN_W-1:0]   num_vec_r, num_vec_s;
    logic               pipe_busy_s;

    // Next-value signals for the registered outputs
    logic               busy_s, done_s, w_rd_en_s, a_rd_en_s;
    logic [AW-1:0]      w_rd_addr_s;
    logic [LEN_W-1:0]   a_rd_addr_s;

    // Output registers
    logic               busy_r, done_r, w_rd_en_r, w_shift_en_r, a_rd_en_r;
    logic [AW-1:0]      w_rd_addr_r;
    logic [LEN_W-1:0]   a_rd_addr_r;

    // Bit k is a_rd_en delayed k+1 cycles: low half feeds the rows, high half the columns
    logic [2*N-1:0]     pipe_r;

    // Next-state, counter and output-decode logic
    always_comb begin
        state_s     = state_r;
        w_cnt_s     = w_cnt_r;
        v_cnt_s     = v_cnt_r;
        num_vec_s   = num_vec_r;
        // Pipeline contents after this edge; DRAIN exits once that is empty
        pipe_busy_s = (|pipe_r[2*N-2:0]) | a_rd_en_r;

        case (state_r)
            IDLE: begin
                if (start) begin
                    num_vec_s = num_vec;
                    if (num_vec == {LEN_W{1'b0}}) begin
                        state_s = FIN;
                    end else if (reuse_w) begin
                        state_s = COMPUTE;
                        v_cnt_s = {LEN_W{1'b0}};
                    end else begin
                        state_s = LOAD_W;
                        w_cnt_s = AW'(N - 1);
                    end
                end else begin
                    state_s = IDLE;
                end
            end
            LOAD_W: begin
                // Rows are fetched bottom-first so the last row ends up deepest
                if (w_cnt_r == {AW{1'b0}}) begin
                    state_s = COMPUTE;
                    v_cnt_s = {LEN_W{1'b0}};
                end else begin
                    w_cnt_s = w_cnt_r - AW'(1);
                end
            end
            COMPUTE: begin
                // Compare against count-1 so the full 2^LEN_W-1 range never wraps
                if (v_cnt_r == (num_vec_r - LEN_W'(1))) begin
                    state_s = DRAIN;
                end else begin
                    v_cnt_s = v_cnt_r + LEN_W'(1);
                end
            end
            DRAIN: begin
                if (!pipe_busy_s) begin
                    state_s = FIN;
                end else begin
                    state_s = DRAIN;
                end
            end
            FIN: begin
                state_s = IDLE;
            end
            default: begin
                state_s = IDLE;
            end
        endcase

        busy_s      = (state_s == LOAD_W) || (state_s == COMPUTE) || (state_s == DRAIN);
        done_s      = (state_s == FIN);
        w_rd_en_s   = (state_s == LOAD_W);
        a_rd_en_s   = (state_s == COMPUTE);
        w_rd_addr_s = w_rd_en_s ? w_cnt_s : {AW{1'b0}};
        a_rd_addr_s = a_rd_en_s ? v_cnt_s : {LEN_W{1'b0}};
    end

    // State, counters, output registers and the valid delay pipeline
    always_ff @(posedge clk) begin
        if (rst) begin
            state_r      <= IDLE;
            w_cnt_r      <= {AW{1'b0}};
            v_cnt_r      <= {LEN_W{1'b0}};
            num_vec_r    <= {LEN_W{1'b0}};
            busy_r       <= 1'b0;
            done_r       <= 1'b0;
            w_rd_en_r    <= 1'b0;
            w_rd_addr_r  <= {AW{1'b0}};
            w_shift_en_r <= 1'b0;
            a_rd_en_r    <= 1'b0;
            a_rd_addr_r  <= {LEN_W{1'b0}};
            pipe_r       <= {(2*N){1'b0}};
        end else begin
            state_r      <= state_s;
            w_cnt_r      <= w_cnt_s;
            v_cnt_r      <= v_cnt_s;
            num_vec_r    <= num_vec_s;
            busy_r       <= busy_s;
            done_r       <= done_s;
            w_rd_en_r    <= w_rd_en_s;
            w_rd_addr_r  <= w_rd_addr_s;
            // Weight data arrives one cycle after the read, so the shift follows it
            w_shift_en_r <= w_rd_en_r;
            a_rd_en_r    <= a_rd_en_s;
            a_rd_addr_r  <= a_rd_addr_s;
            pipe_r       <= {pipe_r[2*N-2:0], a_rd_en_r};
        end
    end

    assign busy          = busy_r;
    assign done          = done_r;
    assign w_rd_en       = w_rd_en_r;
    assign w_rd_addr     = w_rd_addr_r;
    assign w_shift_en    = w_shift_en_r;
    assign a_rd_en       = a_rd_en_r;
    assign a_rd_addr     = a_rd_addr_r;
    assign row_valid     = pipe_r[N-1:0];
    assign col_out_valid = pipe_r[2*N-1:N];

endmodule

// File: doc/sa_sched.md
# sa_sched

Sequencing controller for the N×N weight-stationary systolic array of MAC processing elements. Each job starts with a start pulse. The block then:
- fetches and shifts a weight tile into the array, unless reuse is requested;
- streams activation vectors with the per-row skew the array needs;
- tracks results as they drain out of the bottom row, and raises per-column output-valid strobes.

It sits between the weight/activation buffers, the array, and the output collector. It drives the weight-clock gate enable and the buffer read ports.

## Interface
Parameters:
- N, 8, array dimension: rows = columns = N
- LEN_W, 8, width of the vector count and activation address
- AW, $clog2(N), width of the weight row address

Ports:
- clk  in  1  single clock for all logic
- rst  in  1  reset, synchronous, active-high
- start  in  1  job request, sampled only in IDLE
- reuse_w  in  1  sampled with start; 1 skips LOAD_W and keeps the resident weights
- num_vec  in  LEN_W  number of activation vectors in the job, sampled with start
- busy  out  1  high from the first cycle after an accepted start through the last DRAIN cycle
- done  out  1  one-cycle pulse at job completion
- w_rd_en  out  1  weight buffer read enable
- w_rd_addr  out  AW  weight row address
- w_shift_en  out  1  enable for the array weight-clock gate; shifts one weight row down the array
- a_rd_en  out  1  activation buffer read enable
- a_rd_addr  out  LEN_W  activation vector address
- row_valid  out  N  bit i is high when row i's activation input to column 0 is valid
- col_out_valid  out  N  bit j is high when the bottom-row partial sum of column j is valid

## Operation
- States: IDLE, LOAD_W, COMPUTE, DRAIN, FIN.
- IDLE, start=1, num_vec=0: go to FIN. No reads occur.
- IDLE, start=1, reuse_w=0: go to LOAD_W.
- IDLE, start=1, reuse_w=1: go to COMPUTE.
- start, reuse_w and num_vec are latched on acceptance. Changes on these inputs while busy have no effect.
- LOAD_W:
  - lasts exactly N cycles with w_rd_en=1;
  - w_rd_addr counts N-1 down to 0, so the last row is fetched first;
  - then go to COMPUTE.
- w_shift_en = w_rd_en delayed 1 cycle, matching the 1-cycle buffer read latency.
- COMPUTE:
  - lasts exactly num_vec cycles with a_rd_en=1;
  - a_rd_addr counts 0 up to num_vec-1;
  - then go to DRAIN.
- row_valid[i] = a_rd_en delayed (1+i) cycles. This is 1 cycle of read latency plus the row skew.
- col_out_valid[j] = row_valid[0] delayed (N+j) cycles. This matches the registered activation path across columns and the partial-sum path down rows.
- Implement the delays as a single a_rd_en shift register, 2N deep.
- DRAIN: stay until the whole delay pipeline is zero, then go to FIN.
- FIN: done=1 for one cycle, busy=0, go to IDLE. A start in the FIN cycle is ignored.
- Counter widths:
  - vector counter is LEN_W bits, compared against the latched num_vec;
  - num_vec = 2^LEN_W-1 must complete with no wrap.
- Reset:
  - all outputs are 0, state is IDLE, and the delay pipeline is cleared;
  - applies from the first edge where rst=1, including mid-job;
  - no residual valids after reset.

## Timing
Cycle 0 is the edge where start is sampled. With reuse_w=0, V=num_vec≥1:
- w_rd_en: cycles 1..N
- w_shift_en: cycles 2..N+1
- a_rd_en: cycles N+1..N+V
- row_valid[i]: cycles N+2+i..N+1+V+i
- col_out_valid[j]: cycles 2N+2+j..2N+1+V+j
- last valid: col_out_valid[N-1] at 3N+V
- FIN/done: cycle 3N+V+1
- busy: cycles 1..3N+V

Resident weights are stable before the first row_valid[0]. The last w_shift_en is at N+1; row_valid[0] first rises at N+2.

With reuse_w=1, all activation-side times shift earlier by N:
- a_rd_en starts at cycle 1
- done at 2N+V+1

Back-to-back jobs: the earliest next accepted start is the cycle after done.

## Test plan
- N=4, num_vec=3, reuse_w=0, start at cycle 0 ->
  - w_rd_en cycles 1-4 with addr 3,2,1,0; w_shift_en cycles 2-5;
  - a_rd_en cycles 5-7 with addr 0,1,2;
  - row_valid[0] cycles 6-8, row_valid[3] cycles 9-11;
  - col_out_valid[0] cycles 10-12, col_out_valid[3] cycles 13-15;
  - done at 16; busy 1-15.
- Same job with reuse_w=1 -> no w_rd_en or w_shift_en; a_rd_en cycles 1-3; done at 12.
- num_vec=0 -> done at cycle 1; busy, w_rd_en and a_rd_en never asserted.
- Start pulsed every cycle during the N=4, V=3 job, including the FIN cycle -> no second job. A start at cycle 17 begins an identical job offset by 17.
- rst=1 at cycle 7 of the first job -> from cycle 8 every output is 0 and stays 0 until the next start, with no col_out_valid pulses afterwards.
- LEN_W=4, num_vec=15 -> 15 a_rd_en cycles with addr 0..15-1 and no wrap; done at 3N+16 = 28 for N=4.
